tsc_error_monitor: RTL

- Registered monitor sitting directly downstream of the 16-bit two-rail TSC checker tree; consumes the final two-rail pair (f, g).
- Valid codewords: 01 and 10. Invalid codewords: 00 and 11.
- Filters transient invalid codewords with a consecutive-sample threshold, raises an interrupt with an ack handshake, keeps a sticky fault flag, and keeps a saturating count of invalid samples for the system error handler.

---
 rtl/tsc_error_monitor.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/tsc_error_monitor.sv
// Registered fault monitor for the final two-rail pair of the TSC checker tree.
// Optional window toggle check is built only when TSC_TOGGLE_CHECK_EN is defined.
module tsc_error_monitor #(
    parameter int THRESH = 2,
    parameter int CNT_W  = 8,
    parameter int WINDOW = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             f,
    input  logic             g,
    input  logic             chk_valid,
    input  logic             err_ack,
    input  logic             err_clr,
    output logic             err_irq,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]       err_state,
    output logic             no_toggle
);

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_SUSPECT = 2'b01,
        ST_FAULT   = 2'b10,
        ST_UNUSED  = 2'b11
    } state_t;

    localparam logic [3:0] THRESH_C = 4'(THRESH);

    state_t           state_q, state_d;
    logic [3:0]       consec_q, consec_d;
    logic             irq_q, irq_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cntBase;
    logic [3:0]       consecInc;
    logic             bad, good, enterFault;

    assign bad       = chk_valid & ~(f ^ g);
    assign good      = chk_valid &  (f ^ g);
    assign consecInc = consec_q + 4'd1;

    // Next-state decision is made on the current sample; ack in FAULT beats any bad sample.
    always_comb begin
        state_d  = state_q;
        consec_d = consec_q;
        case (state_q)
            ST_OK: begin
                if (bad) begin
                    if (THRESH_C == 4'd1) begin
                        state_d  = ST_FAULT;
                        consec_d = THRESH_C;
                    end else begin
                        state_d  = ST_SUSPECT;
                        consec_d = 4'd1;
                    end
                end
            end
            ST_SUSPECT: begin
                if (good) begin
                    state_d  = ST_OK;
                    consec_d = 4'd0;
                end else if (bad) begin
                    if (consecInc == THRESH_C) begin
                        state_d  = ST_FAULT;
                        consec_d = THRESH_C;
                    end else begin
                        consec_d = consecInc;
                    end
                end
            end
            ST_FAULT: begin
                if (err_ack) begin
                    state_d  = ST_OK;
                    consec_d = 4'd0;
                end else begin
                    consec_d = THRESH_C;
                end
            end
            default: begin
                state_d  = ST_OK;
                consec_d = 4'd0;
            end
        endcase

        enterFault = (state_d == ST_FAULT) && (state_q != ST_FAULT);
        irq_d      = (state_d == ST_FAULT);
        sticky_d   = (err_clr ? 1'b0 : sticky_q) | enterFault;

        cntBase = err_clr ? '0 : cnt_q;
        cnt_d   = cntBase;
        if (bad && (cntBase != {CNT_W{1'b1}})) begin
            cnt_d = cntBase + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_OK;
            consec_q <= 4'd0;
            irq_q    <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            consec_q <= consec_d;
            irq_q    <= irq_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign err_state  = state_q;
    assign err_irq    = irq_q;
    assign err_sticky = sticky_q;
    assign err_cnt    = cnt_q;

`ifdef TSC_TOGGLE_CHECK_EN
    localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    logic [WIN_W-1:0] winCnt_q;
    logic             seen01_q, seen10_q, noToggle_q;
    logic             is01, is10, blockEnd;

    assign is01     = chk_valid & ~f &  g;
    assign is10     = chk_valid &  f & ~g;
    assign blockEnd = chk_valid && (winCnt_q == WIN_W'(WINDOW - 1));

    // The closing sample of a block is folded into the seen flags before judging it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            winCnt_q   <= '0;
            seen01_q   <= 1'b0;
            seen10_q   <= 1'b0;
            noToggle_q <= 1'b0;
        end else begin
            if (blockEnd) begin
                winCnt_q <= '0;
                seen01_q <= 1'b0;
                seen10_q <= 1'b0;
            end else if (chk_valid) begin
                winCnt_q <= winCnt_q + 1'b1;
                seen01_q <= seen01_q | is01;
                seen10_q <= seen10_q | is10;
            end
            if (blockEnd && (!(seen01_q | is01) || !(seen10_q | is10))) begin
                noToggle_q <= 1'b1;
            end else if (err_clr) begin
                noToggle_q <= 1'b0;
            end
        end
    end

    assign no_toggle = noToggle_q;
`else
    logic [31:0] unused_window;
    assign unused_window = 32'(WINDOW);
    assign no_toggle     = 1'b0;
`endif

endmodule
